// File: rtl/dadda_multiplier.sv
// 16x16 unsigned Dadda-tree multiplier with a registered 32-bit product.
// The 256 partial products are reduced column-wise through heights
// 16 -> 13 -> 9 -> 6 -> 4 -> 3 -> 2 using full/half adders only, then a
// 32-bit carry-propagate adder forms the product (carry-out dropped).
// Optional macro DADDA_PIPE_EN inserts a register after the 4-row stage,
// raising latency from 1 to 2 cycles without changing throughput.
module dadda_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [16:1] a,
  input  logic [16:1] b,
  output logic [32:1] c,
  output logic        out_valid
);

  // Bit matrix indexed [column][row]; heights track how many rows are live.
  typedef logic [31:0][15:0] mat_t;
  typedef logic [31:0][4:0]  hgt_t;
  typedef struct packed {
    mat_t m;
    hgt_t h;
  } red_t;

  // Lay out pp(i,j) = a(i) & b(j) in column i+j-2, packed from row 0 up.
  function automatic red_t pp_init(input logic [16:1] x, input logic [16:1] y);
    red_t r;
    int   p;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        p = int'(r.h[i+j]);
        r.m[i+j][p] = x[i+1] & y[j+1];
        r.h[i+j] = r.h[i+j] + 5'd1;
      end
    end
    return r;
  endfunction

  // One Dadda stage: in every column use just enough adders so that the
  // remaining bits plus carries arriving from the column below fit in d.
  // Heights are structural constants, so every loop folds to fixed wiring.
  function automatic red_t dadda_stage(input red_t r, input int d);
    red_t o;
    int   hc, exc, nfa, nha, k, pos, pc;
    logic s, co;
    o = '0;
    for (int col = 0; col < 32; col++) begin
      hc  = int'(r.h[col]);
      pos = int'(o.h[col]);            // carries already placed by col-1
      exc = hc + pos - d;
      nfa = (exc > 0) ? exc / 2 : 0;
      nha = (exc > 0) ? exc % 2 : 0;
      k   = 0;
      for (int f = 0; f < nfa; f++) begin
        s  = r.m[col][k] ^ r.m[col][k+1] ^ r.m[col][k+2];
        co = (r.m[col][k] & r.m[col][k+1]) | (r.m[col][k] & r.m[col][k+2]) |
             (r.m[col][k+1] & r.m[col][k+2]);
        o.m[col][pos] = s;
        pos++;
        if (col < 31) begin
          pc = int'(o.h[col+1]);
          o.m[col+1][pc] = co;
          o.h[col+1] = o.h[col+1] + 5'd1;
        end
        k += 3;
      end
      for (int f = 0; f < nha; f++) begin
        s  = r.m[col][k] ^ r.m[col][k+1];
        co = r.m[col][k] & r.m[col][k+1];
        o.m[col][pos] = s;
        pos++;
        if (col < 31) begin
          pc = int'(o.h[col+1]);
          o.m[col+1][pc] = co;
          o.h[col+1] = o.h[col+1] + 5'd1;
        end
        k += 2;
      end
      while (k < hc) begin
        o.m[col][pos] = r.m[col][k];
        pos++;
        k++;
      end
      o.h[col] = 5'(pos);
    end
    return o;
  endfunction

  // Final carry-propagate add of the two surviving rows; carry-out dropped.
  function automatic logic [31:0] cpa(input red_t r);
    logic [31:0] x, y;
    for (int col = 0; col < 32; col++) begin
      x[col] = r.m[col][0];
      y[col] = r.m[col][1];
    end
    return x + y;
  endfunction

  red_t        pp_p0;
  red_t        r4_p0;
  logic [31:0] sum_last;
  logic        vld_last;

  // ---- stage p0: partial products reduced down to four rows ----
  // Partial-product generation and the first four reduction stages.
  always_comb begin
    pp_p0 = pp_init(a, b);
    r4_p0 = dadda_stage(dadda_stage(dadda_stage(dadda_stage(pp_p0, 13), 9), 6), 4);
  end

`ifdef DADDA_PIPE_EN
  red_t r4_p1;
  logic vld_p1;

  // ---- stage p1: registered 4-row matrix, then 4 -> 3 -> 2 and CPA ----
  // Capture the 4-row matrix; reset drops any in-flight operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r4_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) r4_p1 <= r4_p0;
    end
  end

  assign sum_last = cpa(dadda_stage(dadda_stage(r4_p1, 3), 2));
  assign vld_last = vld_p1;
`else
  assign sum_last = cpa(dadda_stage(dadda_stage(r4_p0, 3), 2));
  assign vld_last = in_valid;
`endif

  // ---- output register: product held until the next valid result ----
  // Register the product; c holds and out_valid drops when no new result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_last;
      if (vld_last) c <= sum_last;
    end
  end

endmodule

// File: tb/tb_dadda_multiplier.sv
// Self-checking bench for dadda_multiplier: table-driven directed vectors,
// hand-written reset/hold sequences and a random run, all checked through a
// scoreboard queue that also verifies output latency.
module tb_dadda_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b1;
  logic [16:1] a = 16'd5;
  logic [16:1] b = 16'd7;
  logic [32:1] c;
  logic        out_valid;

`ifdef DADDA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] exp;
    int          cyc;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  sb_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;

  dadda_multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending product.
  always @(negedge clk) begin
    sb_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got out_valid=1 c=%0d, expected no output (t=%0t)", c, $time);
      end else begin
        e = q.pop_front();
        chk("product", c, e.exp);
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp);
    @(posedge clk);
    #1;
    in_valid = v;
    a = x;
    b = y;
    if (v && rst_n) q.push_back('{exp: exp, cyc: cyc});
  endtask

  task automatic drain(input string name);
    drive(1'b0, 16'd0, 16'd0, 32'd0);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] x, y;
    logic        v;

    tbl[0] = '{16'd23479, 16'd23415, 32'd549760785};
    tbl[1] = '{16'd24,    16'd10,    32'd240};
    tbl[2] = '{16'd34543, 16'd0,     32'd0};
    tbl[3] = '{16'd65535, 16'd65535, 32'd4294836225};
    tbl[4] = '{16'd1,     16'd65535, 32'd65535};
    tbl[5] = '{16'd32768, 16'd2,     32'd65536};
    tbl[6] = '{16'd0,     16'd65535, 32'd0};
    tbl[7] = '{16'd40000, 16'd3,     32'd120000};

    // Reset held with valid operands applied: outputs stay cleared.
    repeat (2) begin
      @(negedge clk);
      chk("reset_c", c, 32'd0);
      chk("reset_vld", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Directed vectors back to back, no bubbles.
    for (int i = 0; i < 8; i++) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].exp);
    drain("drain_table");

    // Hold: no valid input, c keeps the last product.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      @(negedge clk);
      chk("hold_c", c, tbl[7].exp);
      chk("hold_vld", {31'b0, out_valid}, 32'd0);
    end

    // Reset pulsed while a product is in flight.
    drive(1'b1, 16'd1234, 16'd5678, 32'd7006652);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'd9;
    b = 16'd9;
    q.delete();
    @(negedge clk);
    chk("rst_mid_c", c, 32'd0);
    chk("rst_mid_vld", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_c", c, 32'd0);
      chk("post_rst_vld", {31'b0, out_valid}, 32'd0);
    end

    // First operation after reset.
    drive(1'b1, 16'd300, 16'd300, 32'd90000);
    drain("drain_first");

    // Random pairs with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      x = 16'($urandom);
      y = 16'($urandom);
      drive(v, x, y, {16'b0, x} * {16'b0, y});
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected finish before 1000000");
    $fatal(1);
  end

endmodule

// File: doc/dadda_multiplier.md
DADDA_MULTIPLIER -- requirements
Module: dadda_multiplier

Interface
REQ-001 Parameters: none; operand widths fixed at 16 bits, product width 32 bits.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  a/b qualifier; operands sampled on a clk rising edge when high.
REQ-006 a  input  [16:1]  unsigned multiplier, bit 1 = LSB.
REQ-007 b  input  [16:1]  unsigned multiplicand, bit 1 = LSB.
REQ-008 c  output  [32:1]  unsigned product a*b, bit 1 = LSB, registered.
REQ-009 out_valid  output  1  high for exactly one cycle when c carries a new product.

Function
REQ-010 c SHALL equal the exact unsigned product a*b; no overflow is possible (65535*65535 fits in 32 bits).
REQ-011 Partial products SHALL be pp(i,j) = a(i) AND b(j), 256 bits, weighted by column i+j-2 (0..30).
REQ-012 Column reduction SHALL follow the Dadda schedule with max column heights 16 -> 13 -> 9 -> 6 -> 4 -> 3 -> 2, built from full and half adders only.
REQ-013 Each stage SHALL use the minimum adders needed to bring every column to the next target height (Dadda rule), carries going to the next-higher column.
REQ-014 The final two rows SHALL be summed by a 32-bit carry-propagate adder; its carry-out is dropped (always 0).
REQ-015 The multiply path from a/b to the output register SHALL be purely combinational; default latency 1 cycle: operands sampled at edge N appear on c with out_valid=1 after edge N.
REQ-016 When in_valid=0 at an edge, c SHALL hold its previous value and out_valid SHALL be 0 after that edge.
REQ-017 Back-to-back in_valid=1 SHALL produce one product per cycle, in order, with no bubbles.
REQ-018 Operand 0 on either input SHALL yield c=0; a=b=65535 SHALL yield c=4294836225.

Reset
REQ-019 When rst_n=0 at a rising edge, c SHALL become 0 and out_valid 0 after that edge, regardless of in_valid.
REQ-020 Reset asserted mid-operation SHALL discard every in-flight operand/product (including the optional pipeline stage); no out_valid pulse for them after reset release.
REQ-021 The first edge with rst_n=1 and in_valid=1 SHALL start normal operation with the latency of REQ-015/REQ-023.

Configuration
REQ-022 Macro DADDA_PIPE_EN selects an extra pipeline register.
REQ-023 With DADDA_PIPE_EN defined: a register SHALL be inserted after the 4-row reduction stage (all intermediate columns plus a valid bit); latency becomes 2 cycles; throughput stays one per cycle; the register is cleared by reset.
REQ-024 Without DADDA_PIPE_EN: no intermediate register; latency 1 cycle as in REQ-015.
REQ-025 The arithmetic result SHALL be identical in both configurations.

Verification
REQ-026 Reset: rst_n=0 for 2 cycles with in_valid=1, a=5, b=7 -> c=0, out_valid=0 throughout.
REQ-027 a=23479, b=23415, in_valid=1 -> c=549760785, out_valid=1 after latency (1 cycle, or 2 with DADDA_PIPE_EN).
REQ-028 Back-to-back: a=24,b=10 then a=34543,b=0 on consecutive cycles -> c=240 then c=0 on consecutive cycles, out_valid high both cycles.
REQ-029 Corners: a=b=65535 -> 4294836225; a=1,b=65535 -> 65535; a=32768,b=2 -> 65536.
REQ-030 Hold/reset: in_valid=0 after a product -> c holds, out_valid=0; rst_n=0 pulsed with a product in flight -> no out_valid for it, c=0.
REQ-031 Random: at least 10000 random a/b pairs in both configurations -> c matches the reference product every time.
